// File: rtl/ps2_tune_if.sv
// Byte-stream inputs (PS/2, UART) and tuning-word outputs of ps2_tune_ctrl.
// The slave modport is the controller side; the master modport is the byte sources and the consumer side.
interface ps2_tune_if #(
    parameter int FW = 16
) ();
    logic [7:0]    ps2_byte;
    logic          ps2_valid;
    logic [7:0]    uart_byte;
    logic          uart_valid;
    logic [FW-1:0] freq_word;
    logic          freq_upd;
    logic [2:0]    step_sel;
    logic          src_last;
    logic          cmd_drop;

    modport slave (
        input  ps2_byte, ps2_valid, uart_byte, uart_valid,
        output freq_word, freq_upd, step_sel, src_last, cmd_drop
    );

    modport master (
        output ps2_byte, ps2_valid, uart_byte, uart_valid,
        input  freq_word, freq_upd, step_sel, src_last, cmd_drop
    );
endinterface

// File: rtl/ps2_tune_ctrl.sv
// Decodes PS/2 scancodes and UART bytes into tune commands and applies them round-robin to a saturating tuning word.
// Define TUNE_TIMEOUT_EN to return the PS/2 prefix FSM to IDLE after TIMEOUT_CYC cycles without a byte.
module ps2_tune_ctrl #(
    parameter int            FW          = 16,
    parameter logic [FW-1:0] FREQ_INIT   = 16'h0400,
    parameter logic [FW-1:0] FREQ_MIN    = 16'h0001,
    parameter logic [FW-1:0] FREQ_MAX    = 16'hFFF0,
    parameter int            TIMEOUT_CYC = 100000
) (
    input  logic      clk,
    input  logic      rst_n,
    ps2_tune_if.slave bus
);
    typedef enum logic [1:0] {OP_INC, OP_DEC, OP_RST, OP_STEP} op_e;
    typedef struct packed {
        logic       vld;
        op_e        op;
        logic [2:0] k;
    } cmd_t;
    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK} ps2_st_e;

    localparam cmd_t CMD_NONE = '{vld: 1'b0, op: OP_INC, k: 3'd0};

    function automatic cmd_t mk_cmd(input op_e op, input logic [2:0] k);
        return '{vld: 1'b1, op: op, k: k};
    endfunction

    ps2_st_e       st_q, st_d;
    cmd_t          ps2_cmd, uart_cmd, gnt_cmd;
    cmd_t          ps2_slot_q, ps2_slot_d, uart_slot_q, uart_slot_d;
    logic          rr_q, rr_d;
    logic          gnt_ps2, gnt_uart;
    logic [FW-1:0] freq_q, freq_d;
    logic [2:0]    step_q, step_d;
    logic          upd_q, upd_d, src_q, src_d, drop_q, drop_d;
    logic [FW:0]   step_val, sum, diff;

`ifdef TUNE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    assign to_cnt_d = (bus.ps2_valid || st_q == S_IDLE) ? '0 : to_cnt_q + 1'b1;
`endif

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        st_d    = st_q;
        ps2_cmd = CMD_NONE;
        if (bus.ps2_valid) begin
            case (st_q)
                S_IDLE: begin
                    if (bus.ps2_byte == 8'hE0)      st_d = S_EXT;
                    else if (bus.ps2_byte == 8'hF0) st_d = S_BRK;
                    else begin
                        case (bus.ps2_byte)
                            8'h16:   ps2_cmd = mk_cmd(OP_STEP, 3'd0);
                            8'h1E:   ps2_cmd = mk_cmd(OP_STEP, 3'd1);
                            8'h26:   ps2_cmd = mk_cmd(OP_STEP, 3'd2);
                            8'h25:   ps2_cmd = mk_cmd(OP_STEP, 3'd3);
                            8'h2E:   ps2_cmd = mk_cmd(OP_STEP, 3'd4);
                            8'h36:   ps2_cmd = mk_cmd(OP_STEP, 3'd5);
                            8'h3D:   ps2_cmd = mk_cmd(OP_STEP, 3'd6);
                            8'h3E:   ps2_cmd = mk_cmd(OP_STEP, 3'd7);
                            8'h2D:   ps2_cmd = mk_cmd(OP_RST, 3'd0);
                            default: ps2_cmd = CMD_NONE;
                        endcase
                    end
                end
                S_EXT: begin
                    st_d = (bus.ps2_byte == 8'hF0) ? S_EXTBRK : S_IDLE;
                    if (bus.ps2_byte == 8'h75)      ps2_cmd = mk_cmd(OP_INC, 3'd0);
                    else if (bus.ps2_byte == 8'h72) ps2_cmd = mk_cmd(OP_DEC, 3'd0);
                end
                default: st_d = S_IDLE;  // break code byte is swallowed
            endcase
        end
`ifdef TUNE_TIMEOUT_EN
        else if (st_q != S_IDLE && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            st_d = S_IDLE;
        end
`endif
    end

    always_comb begin
        uart_cmd = CMD_NONE;
        if (bus.uart_valid) begin
            if (bus.uart_byte[7:3] == 5'b00110)  uart_cmd = mk_cmd(OP_STEP, bus.uart_byte[2:0]);
            else if (bus.uart_byte == 8'h55)     uart_cmd = mk_cmd(OP_INC, 3'd0);
            else if (bus.uart_byte == 8'h44)     uart_cmd = mk_cmd(OP_DEC, 3'd0);
            else if (bus.uart_byte == 8'h52)     uart_cmd = mk_cmd(OP_RST, 3'd0);
        end
    end

    // Round-robin grant; a slot granted this cycle may be refilled in the same cycle without a drop.
    always_comb begin
        gnt_ps2  = ps2_slot_q.vld && (!uart_slot_q.vld || !rr_q);
        gnt_uart = uart_slot_q.vld && !gnt_ps2;
        gnt_cmd  = gnt_ps2 ? ps2_slot_q : uart_slot_q;

        rr_d = rr_q;
        if (gnt_ps2)       rr_d = 1'b1;
        else if (gnt_uart) rr_d = 1'b0;

        ps2_slot_d  = ps2_cmd.vld  ? ps2_cmd  : (gnt_ps2  ? CMD_NONE : ps2_slot_q);
        uart_slot_d = uart_cmd.vld ? uart_cmd : (gnt_uart ? CMD_NONE : uart_slot_q);
        drop_d = drop_q
               | (ps2_cmd.vld  && ps2_slot_q.vld  && !gnt_ps2)
               | (uart_cmd.vld && uart_slot_q.vld && !gnt_uart);
    end

    // Arithmetic one bit wider than the word so overflow and borrow are visible before clamping.
    always_comb begin
        step_val = (FW+1)'(1) << {step_q, 1'b0};
        sum      = {1'b0, freq_q} + step_val;
        diff     = {1'b0, freq_q} - step_val;
        freq_d   = freq_q;
        step_d   = step_q;
        upd_d    = 1'b0;
        src_d    = src_q;
        if (gnt_ps2 || gnt_uart) begin
            upd_d = 1'b1;
            src_d = gnt_uart;
            case (gnt_cmd.op)
                OP_INC:  freq_d = (sum > {1'b0, FREQ_MAX}) ? FREQ_MAX : sum[FW-1:0];
                OP_DEC:  freq_d = (diff[FW] || diff[FW-1:0] < FREQ_MIN) ? FREQ_MIN : diff[FW-1:0];
                OP_RST:  freq_d = FREQ_INIT;
                default: step_d = gnt_cmd.k;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= S_IDLE;
            ps2_slot_q  <= CMD_NONE;
            uart_slot_q <= CMD_NONE;
            rr_q        <= 1'b0;
            freq_q      <= FREQ_INIT;
            step_q      <= 3'd0;
            upd_q       <= 1'b0;
            src_q       <= 1'b0;
            drop_q      <= 1'b0;
`ifdef TUNE_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            st_q        <= st_d;
            ps2_slot_q  <= ps2_slot_d;
            uart_slot_q <= uart_slot_d;
            rr_q        <= rr_d;
            freq_q      <= freq_d;
            step_q      <= step_d;
            upd_q       <= upd_d;
            src_q       <= src_d;
            drop_q      <= drop_d;
`ifdef TUNE_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign bus.freq_word = freq_q;
    assign bus.freq_upd  = upd_q;
    assign bus.step_sel  = step_q;
    assign bus.src_last  = src_q;
    assign bus.cmd_drop  = drop_q;
endmodule

// File: tb/tb_ps2_tune_ctrl.sv
// Scoreboard bench for ps2_tune_ctrl: stimulus pushes expected updates, a negedge monitor pops on each freq_upd.
// Prefix-timeout expectations follow TUNE_TIMEOUT_EN, with TIMEOUT_CYC overridden to 16.
module tb_ps2_tune_ctrl;
    localparam int M_INC = 0, M_DEC = 1, M_RST = 2, M_STEP = 3;

    typedef struct {
        logic [15:0] freq;
        logic [2:0]  step;
        logic        src;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ps2_tune_if #(.FW(16)) bus ();

    ps2_tune_ctrl #(.FW(16), .TIMEOUT_CYC(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          ncyc = 0;
    int          drive_cyc = 0;
    logic [15:0] m_freq = 16'h0400;
    logic [2:0]  m_step = 3'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Model of one applied command; `extra` is the arbitration delay beyond the two-cycle latency.
    task automatic model_apply(input logic src, input int op, input int k, input int extra);
        logic [16:0] st, t;
        exp_t e;
        st = 17'd1 << (2 * m_step);
        case (op)
            M_INC: begin
                t = {1'b0, m_freq} + st;
                m_freq = (t > 17'h0FFF0) ? 16'hFFF0 : t[15:0];
            end
            M_DEC:   m_freq = (st >= {1'b0, m_freq}) ? 16'h0001 : m_freq - st[15:0];
            M_RST:   m_freq = 16'h0400;
            default: m_step = 3'(k);
        endcase
        e.freq = m_freq;
        e.step = m_step;
        e.src  = src;
        e.due  = drive_cyc + 2 + extra;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (bus.freq_upd === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_upd: freq_upd=1 with freq_word=%0h, expected no update (cycle %0d)",
                             bus.freq_word, ncyc);
                end else begin
                    e = sb.pop_front();
                    check("upd_cycle", ncyc, e.due);
                    check("upd_freq", bus.freq_word, e.freq);
                    check("upd_step", bus.step_sel, e.step);
                    check("upd_src", bus.src_last, e.src);
                end
            end
        end
    end

    task automatic drive(input logic pv, input logic [7:0] pb, input logic uv, input logic [7:0] ub);
        @(negedge clk);
        #1;
        drive_cyc      = ncyc;
        bus.ps2_valid  = pv;
        bus.ps2_byte   = pb;
        bus.uart_valid = uv;
        bus.uart_byte  = ub;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic ps2(input logic [7:0] b);
        drive(1'b1, b, 1'b0, 8'h00);
    endtask

    task automatic uc(input logic [7:0] b, input int op, input int k);
        drive(1'b0, 8'h00, 1'b1, b);
        model_apply(1'b1, op, k, 0);
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d updates still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        drain();
        rst_n          = 1'b0;
        bus.ps2_valid  = 1'b0;
        bus.uart_valid = 1'b0;
        bus.ps2_byte   = 8'h00;
        bus.uart_byte  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_freq", bus.freq_word, 16'h0400);
        check("rst_step", bus.step_sel, 3'd0);
        check("rst_upd", bus.freq_upd, 1'b0);
        check("rst_src", bus.src_last, 1'b0);
        check("rst_drop", bus.cmd_drop, 1'b0);
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        m_freq = 16'h0400;
        m_step = 3'd0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.ps2_valid  = 1'b0;
        bus.uart_valid = 1'b0;
        bus.ps2_byte   = 8'h00;
        bus.uart_byte  = 8'h00;
        #1;
        do_reset();

        // Extended make increments; extended break, bare 75 and a plain break are all ignored.
        ps2(8'hE0); ps2(8'h75); model_apply(1'b0, M_INC, 0, 0);
        idle(4);
        check("t2_inc", bus.freq_word, 16'h0401);
        ps2(8'hE0); ps2(8'hF0); ps2(8'h75);
        ps2(8'h75);
        ps2(8'hF0); ps2(8'h16);
        idle(4);
        check("t2_ignored", bus.freq_word, 16'h0401);
        check("t2_step", bus.step_sel, 3'd0);

        do_reset();
        ps2(8'h26); model_apply(1'b0, M_STEP, 2, 0);
        ps2(8'hE0); ps2(8'h75); model_apply(1'b0, M_INC, 0, 0);
        idle(4);
        check("t3_step", bus.step_sel, 3'd2);
        check("t3_freq", bus.freq_word, 16'h0410);
        uc(8'h52, M_RST, 0);
        idle(4);
        check("t3_rst", bus.freq_word, 16'h0400);
        check("t3_src", bus.src_last, 1'b1);

        // Reset in the middle of a prefix discards it: a following 75 is a non-extended code.
        ps2(8'hE0);
        do_reset();
        ps2(8'h75);
        idle(4);
        check("t4_rst_prefix", bus.freq_word, 16'h0400);

        // Simultaneous PS/2 INC and UART DEC: PS/2 first, UART one cycle later.
        ps2(8'hE0);
        drive(1'b1, 8'h75, 1'b1, 8'h44);
        model_apply(1'b0, M_INC, 0, 0);
        model_apply(1'b1, M_DEC, 0, 1);
        idle(5);
        check("t4_net", bus.freq_word, 16'h0400);

        // Saturation at both bounds via back-to-back UART commands.
        uc(8'h37, M_STEP, 7);
        repeat (4) uc(8'h55, M_INC, 0);
        uc(8'h31, M_STEP, 1);
        uc(8'h44, M_DEC, 0);
        uc(8'h30, M_STEP, 0);
        uc(8'h44, M_DEC, 0);
        uc(8'h44, M_DEC, 0);
        uc(8'h32, M_STEP, 2);
        uc(8'h78, M_INC, 0);
        void'(sb.pop_back());
        idle(4);
        check("t5_pre", bus.freq_word, 16'hFFEA);
        check("t5_pre_step", bus.step_sel, 3'd2);
        uc(8'h55, M_INC, 0);
        idle(4);
        check("t5_max", bus.freq_word, 16'hFFF0);
        uc(8'h52, M_RST, 0);
        uc(8'h34, M_STEP, 4);
        repeat (4) uc(8'h44, M_DEC, 0);
        idle(4);
        check("t5_floor", bus.freq_word, 16'h0001);
        uc(8'h30, M_STEP, 0);
        repeat (4) uc(8'h55, M_INC, 0);
        uc(8'h32, M_STEP, 2);
        uc(8'h44, M_DEC, 0);
        idle(4);
        check("t5_min", bus.freq_word, 16'h0001);
        check("t5_no_drop", bus.cmd_drop, 1'b0);

        // Stale E0 prefix across a long idle gap.
        ps2(8'hE0);
        idle(20);
        ps2(8'h75);
`ifndef TUNE_TIMEOUT_EN
        model_apply(1'b0, M_INC, 0, 0);
`endif
        idle(4);
`ifdef TUNE_TIMEOUT_EN
        check("t6_timeout", bus.freq_word, 16'h0001);
`else
        check("t6_no_timeout", bus.freq_word, 16'h0011);
`endif

        // UART slot overwritten while PS/2 holds the grant: first UART command lost, drop flag sticks.
        do_reset();
        drive(1'b1, 8'h16, 1'b1, 8'h55);
        model_apply(1'b0, M_STEP, 0, 0);
        uc(8'h44, M_DEC, 0);
        idle(5);
        check("t7_freq", bus.freq_word, 16'h03FF);
        check("t7_drop", bus.cmd_drop, 1'b1);
        idle(3);
        check("t7_drop_sticky", bus.cmd_drop, 1'b1);

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
